// File: rtl/bkt_var_sweep.sv
// Backtrack/restart sweeper over the packed variable-state BRAM (LANES variables per word).
// Define BKT_SWEEP_STATS_EN to build the flip/clear lane counters; otherwise both read 0.
module bkt_var_sweep #(
  parameter int WIDTH_VAR             = 12,
  parameter int WIDTH_LVL             = 16,
  parameter int LANES                 = 2,
  parameter int ADDR_WIDTH_VAR_STATES = 9,
  parameter int RD_LATENCY            = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_bkt_i,
  input  logic                                 mode_i,
  input  logic [WIDTH_VAR-1:0]                 nv_all_i,
  input  logic [WIDTH_LVL-1:0]                 bkt_lvl_i,
  output logic                                 apply_bkt_o,
  output logic                                 done_bkt_o,
  output logic [ADDR_WIDTH_VAR_STATES-1:0]     ram_raddr_vs_o,
  input  logic [LANES*(3+WIDTH_LVL)-1:0]       ram_rdata_vs_i,
  output logic                                 ram_we_vs_o,
  output logic [ADDR_WIDTH_VAR_STATES-1:0]     ram_waddr_vs_o,
  output logic [LANES*(3+WIDTH_LVL)-1:0]       ram_wdata_vs_o,
  output logic [WIDTH_VAR-1:0]                 flip_cnt_o,
  output logic [WIDTH_VAR-1:0]                 clr_cnt_o
);

  localparam int F  = 3 + WIDTH_LVL;
  localparam int DW = LANES * F;
  localparam int CW = WIDTH_VAR + 1;
  localparam int AW = ADDR_WIDTH_VAR_STATES;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 mode_q, mode_d;
  logic [WIDTH_VAR-1:0] nv_q, nv_d;
  logic [WIDTH_LVL-1:0] lvl_q, lvl_d;
  logic [CW-1:0]        nwords_q, nwords_d;
  logic [CW-1:0]        issue_idx_q, issue_idx_d;
  logic [2:0]           drain_q, drain_d;
  logic [AW-1:0]        raddr_q, raddr_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 accept;

  logic [RD_LATENCY-1:0] vld_sr_q;
  logic [AW-1:0]         addr_sr_q [RD_LATENCY];

  logic                 we_q, we_d;
  logic [AW-1:0]        waddr_q, waddr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [LANES-1:0]     lane_flip, lane_clr;
  logic [2:0]           lane_val;
  logic [WIDTH_LVL-1:0] lane_lvl;
  logic [31:0]          lane_idx;

  assign accept = (state_q == S_IDLE) && start_bkt_i;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    nv_d        = nv_q;
    lvl_d       = lvl_q;
    nwords_d    = nwords_q;
    issue_idx_d = issue_idx_q;
    drain_d     = drain_q;
    raddr_d     = raddr_q;
    rd_vld_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_bkt_i) begin
          state_d     = S_ISSUE;
          mode_d      = mode_i;
          nv_d        = nv_all_i;
          lvl_d       = bkt_lvl_i;
          nwords_d    = CW'((32'(nv_all_i) + 32'(LANES - 1)) / 32'(LANES));
          raddr_d     = '0;
          rd_vld_d    = (nv_all_i != '0);
          issue_idx_d = CW'(1);
        end
      end
      S_ISSUE: begin
        if (issue_idx_q < nwords_q) begin
          raddr_d     = AW'(issue_idx_q);
          rd_vld_d    = 1'b1;
          issue_idx_d = issue_idx_q + CW'(1);
        end else begin
          state_d = S_DRAIN;
          // An empty sweep has no read in flight, so it drains one cycle shorter.
          drain_d = (nwords_q == '0) ? 3'(RD_LATENCY - 1) : 3'(RD_LATENCY);
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'd0) state_d = S_DONE;
        else                 drain_d = drain_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wdata_d   = ram_rdata_vs_i;
    lane_flip = '0;
    lane_clr  = '0;
    lane_val  = '0;
    lane_lvl  = '0;
    lane_idx  = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_val = ram_rdata_vs_i[l*F + WIDTH_LVL +: 3];
      lane_lvl = ram_rdata_vs_i[l*F +: WIDTH_LVL];
      lane_idx = 32'(addr_sr_q[RD_LATENCY-1]) * 32'(LANES) + 32'(l);
      // Flip takes priority over clear for the decision variable at the backtrack level.
      if (lane_idx < 32'(nv_q) && lane_val[2:1] != 2'b00) begin
        if (!mode_q && lane_lvl == lvl_q && !lane_val[0]) begin
          lane_flip[l]      = 1'b1;
          wdata_d[l*F +: F] = {~lane_val[2:1], lane_val[0], lane_lvl};
        end else if (lane_lvl >= lvl_q) begin
          lane_clr[l]       = 1'b1;
          wdata_d[l*F +: F] = '0;
        end
      end
    end
    we_d    = vld_sr_q[RD_LATENCY-1] && ((lane_flip | lane_clr) != '0);
    waddr_d = addr_sr_q[RD_LATENCY-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      nv_q        <= '0;
      lvl_q       <= '0;
      nwords_q    <= '0;
      issue_idx_q <= '0;
      drain_q     <= '0;
      raddr_q     <= '0;
      rd_vld_q    <= 1'b0;
      vld_sr_q    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) addr_sr_q[i] <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      nv_q        <= nv_d;
      lvl_q       <= lvl_d;
      nwords_q    <= nwords_d;
      issue_idx_q <= issue_idx_d;
      drain_q     <= drain_d;
      raddr_q     <= raddr_d;
      rd_vld_q    <= rd_vld_d;
      // Valid/address follow the read through the BRAM latency.
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        vld_sr_q[i]  <= vld_sr_q[i-1];
        addr_sr_q[i] <= addr_sr_q[i-1];
      end
      vld_sr_q[0]  <= rd_vld_q;
      addr_sr_q[0] <= raddr_q;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign apply_bkt_o    = (state_q != S_IDLE);
  assign done_bkt_o     = (state_q == S_DONE);
  assign ram_raddr_vs_o = raddr_q;
  assign ram_we_vs_o    = we_q;
  assign ram_waddr_vs_o = waddr_q;
  assign ram_wdata_vs_o = wdata_q;

`ifdef BKT_SWEEP_STATS_EN
  logic [WIDTH_VAR-1:0] flip_cnt_q, clr_cnt_q;
  logic [WIDTH_VAR-1:0] flip_inc, clr_inc;

  always_comb begin
    flip_inc = '0;
    clr_inc  = '0;
    for (int l = 0; l < LANES; l++) begin
      flip_inc = flip_inc + WIDTH_VAR'(lane_flip[l]);
      clr_inc  = clr_inc + WIDTH_VAR'(lane_clr[l]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flip_cnt_q <= '0;
      clr_cnt_q  <= '0;
    end else if (accept) begin
      flip_cnt_q <= '0;
      clr_cnt_q  <= '0;
    end else if (vld_sr_q[RD_LATENCY-1]) begin
      flip_cnt_q <= flip_cnt_q + flip_inc;
      clr_cnt_q  <= clr_cnt_q + clr_inc;
    end
  end

  assign flip_cnt_o = flip_cnt_q;
  assign clr_cnt_o  = clr_cnt_q;
`else
  assign flip_cnt_o = '0;
  assign clr_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_bkt_var_sweep.sv
// Directed bench for bkt_var_sweep: table of sweeps on an L=1 instance plus
// hand sequences for busy restart, async reset mid-sweep and an L=3 instance.
module tb_bkt_var_sweep;

  localparam int MAXC = 16;

`ifdef BKT_SWEEP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start1, mode1, apply1, done1, we1;
  logic [11:0] nv1, flip1, clr1;
  logic [15:0] lvl1;
  logic [8:0]  raddr1, waddr1;
  logic [37:0] rdata1, wdata1;

  logic        start3, mode3, apply3, done3, we3;
  logic [11:0] nv3, flip3, clr3;
  logic [15:0] lvl3;
  logic [8:0]  raddr3, waddr3;
  logic [37:0] rdata3, wdata3;

  logic [37:0] mem1 [512];
  logic [37:0] mem3 [512];
  logic [37:0] p0, p1;

  bkt_var_sweep #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .start_bkt_i(start1), .mode_i(mode1), .nv_all_i(nv1),
    .bkt_lvl_i(lvl1), .apply_bkt_o(apply1), .done_bkt_o(done1), .ram_raddr_vs_o(raddr1),
    .ram_rdata_vs_i(rdata1), .ram_we_vs_o(we1), .ram_waddr_vs_o(waddr1),
    .ram_wdata_vs_o(wdata1), .flip_cnt_o(flip1), .clr_cnt_o(clr1));

  bkt_var_sweep #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .start_bkt_i(start3), .mode_i(mode3), .nv_all_i(nv3),
    .bkt_lvl_i(lvl3), .apply_bkt_o(apply3), .done_bkt_o(done3), .ram_raddr_vs_o(raddr3),
    .ram_rdata_vs_i(rdata3), .ram_we_vs_o(we3), .ram_waddr_vs_o(waddr3),
    .ram_wdata_vs_o(wdata3), .flip_cnt_o(flip3), .clr_cnt_o(clr3));

  // Read-only BRAM models; writes are only logged and compared.
  always @(posedge clk) rdata1 <= mem1[raddr1];
  always @(posedge clk) begin
    p0     <= mem3[raddr3];
    p1     <= p0;
    rdata3 <= p1;
  end

  typedef struct packed {
    logic        mode;
    logic [11:0] nv;
    logic [15:0] lvl;
    logic [37:0] w0;
    logic [37:0] w1;
    logic [7:0]  doneCyc;
    logic [3:0]  nWr;
    logic [7:0]  cycA;
    logic [8:0]  addrA;
    logic [37:0] dataA;
    logic [7:0]  cycB;
    logic [8:0]  addrB;
    logic [37:0] dataB;
    logic [11:0] flips;
    logic [11:0] clrs;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int errors = 0;

  logic        logWe    [MAXC];
  logic [8:0]  logWaddr [MAXC];
  logic [37:0] logWdata [MAXC];
  logic        logDone  [MAXC];
  logic        logApply [MAXC];

  int cntWe, cntDone, firstDone, lastDone, applyBad;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic record1(input int c);
    logWe[c]    = we1;
    logWaddr[c] = waddr1;
    logWdata[c] = wdata1;
    logDone[c]  = done1;
    logApply[c] = apply1;
  endtask

  task automatic record3(input int c);
    logWe[c]    = we3;
    logWaddr[c] = waddr3;
    logWdata[c] = wdata3;
    logDone[c]  = done3;
    logApply[c] = apply3;
  endtask

  // Apply window: first sweep cycles 1..d1, optional second sweep s2+1..d2.
  task automatic analyze(input int d1, input int s2, input int d2);
    cntWe = 0; cntDone = 0; firstDone = -1; lastDone = -1; applyBad = 0;
    for (int c = 0; c < MAXC; c++) begin
      if (logWe[c] === 1'b1) cntWe++;
      if (logDone[c] === 1'b1) begin
        cntDone++;
        if (firstDone < 0) firstDone = c;
        lastDone = c;
      end
      if (logApply[c] !== ((c >= 1 && c <= d1) || (c >= s2 + 1 && c <= d2))) applyBad++;
    end
  endtask

  // Starts a sweep on the L=1 instance at cycle 0 and logs cycles 0..MAXC-1.
  task automatic applyStimulus(input vec_t v, input int extraA, input int extraB);
    mem1[0] = v.w0;
    mem1[1] = v.w1;
    mode1   = v.mode;
    nv1     = v.nv;
    lvl1    = v.lvl;
    start1  = 1'b1;
    record1(0);
    for (int c = 1; c < MAXC; c++) begin
      @(posedge clk); #1;
      start1 = (c == extraA) || (c == extraB);
      if (c == 1 && extraA == 0) begin
        nv1   = 12'hFFF;
        lvl1  = 16'd0;
        mode1 = ~v.mode;
      end
      record1(c);
    end
  endtask

  initial begin
    rst = 1'b0;
    start1 = 1'b0; mode1 = 1'b0; nv1 = '0; lvl1 = 16'd1;
    start3 = 1'b0; mode3 = 1'b0; nv3 = '0; lvl3 = 16'd1;

    vecs[0] = '{1'b0, 12'd3, 16'd5, {3'b011, 16'd7, 3'b010, 16'd5}, {19'h5A5A5, 3'b100, 16'd2},
                8'd5, 4'd1, 8'd3, 9'd0, {19'd0, 3'b100, 16'd5}, 8'd0, 9'd0, 38'd0, 12'd1, 12'd1};
    vecs[1] = '{1'b1, 12'd3, 16'd5, {3'b011, 16'd7, 3'b010, 16'd5}, {19'h5A5A5, 3'b100, 16'd2},
                8'd5, 4'd1, 8'd3, 9'd0, 38'd0, 8'd0, 9'd0, 38'd0, 12'd0, 12'd2};
    vecs[2] = '{1'b0, 12'd0, 16'd1, {3'b011, 16'd7, 3'b010, 16'd5}, {19'h5A5A5, 3'b100, 16'd2},
                8'd3, 4'd0, 8'd0, 9'd0, 38'd0, 8'd0, 9'd0, 38'd0, 12'd0, 12'd0};
    vecs[3] = '{1'b0, 12'd4, 16'd3, {3'b000, 16'd9, 3'b011, 16'd3}, {3'b010, 16'd2, 3'b100, 16'd3},
                8'd5, 4'd2, 8'd3, 9'd0, {3'b000, 16'd9, 19'd0}, 8'd4, 9'd1,
                {3'b010, 16'd2, 3'b010, 16'd3}, 12'd1, 12'd1};
    vecs[4] = '{1'b0, 12'd1, 16'd1, {3'b010, 16'd1, 3'b010, 16'd1}, 38'd0,
                8'd4, 4'd1, 8'd3, 9'd0, {3'b010, 16'd1, 3'b100, 16'd1}, 8'd0, 9'd0, 38'd0, 12'd1, 12'd0};
    vecs[5] = '{1'b0, 12'd4, 16'd10, {3'b010, 16'd3, 3'b110, 16'd9}, {3'b010, 16'd1, 3'b100, 16'd2},
                8'd5, 4'd0, 8'd0, 9'd0, 38'd0, 8'd0, 9'd0, 38'd0, 12'd0, 12'd0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset apply/done/we", 64'({apply1, done1, we1}), 64'd0);
    checkOutput("reset raddr/waddr", 64'({raddr1, waddr1}), 64'd0);
    checkOutput("reset wdata", 64'(wdata1), 64'd0);
    checkOutput("reset counters", 64'({flip1, clr1}), 64'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], 0, 0);
      analyze(int'(vecs[i].doneCyc), 0, 0);
      checkOutput($sformatf("vec%0d write count", i), 64'(cntWe), 64'(vecs[i].nWr));
      checkOutput($sformatf("vec%0d done count", i), 64'(cntDone), 64'd1);
      checkOutput($sformatf("vec%0d done cycle", i), 64'(firstDone), 64'(vecs[i].doneCyc));
      checkOutput($sformatf("vec%0d apply bad cycles", i), 64'(applyBad), 64'd0);
      if (vecs[i].nWr >= 4'd1) begin
        checkOutput($sformatf("vec%0d write A we", i), 64'(logWe[vecs[i].cycA]), 64'd1);
        checkOutput($sformatf("vec%0d write A addr", i), 64'(logWaddr[vecs[i].cycA]), 64'(vecs[i].addrA));
        checkOutput($sformatf("vec%0d write A data", i), 64'(logWdata[vecs[i].cycA]), 64'(vecs[i].dataA));
      end
      if (vecs[i].nWr >= 4'd2) begin
        checkOutput($sformatf("vec%0d write B we", i), 64'(logWe[vecs[i].cycB]), 64'd1);
        checkOutput($sformatf("vec%0d write B addr", i), 64'(logWaddr[vecs[i].cycB]), 64'(vecs[i].addrB));
        checkOutput($sformatf("vec%0d write B data", i), 64'(logWdata[vecs[i].cycB]), 64'(vecs[i].dataB));
      end
      checkOutput($sformatf("vec%0d flip_cnt", i), 64'(flip1), STATS ? 64'(vecs[i].flips) : 64'd0);
      checkOutput($sformatf("vec%0d clr_cnt", i), 64'(clr1), STATS ? 64'(vecs[i].clrs) : 64'd0);
    end

    // Start re-pulsed at cycle 2 (ignored) and at cycle 6, right after DONE (accepted).
    applyStimulus(vecs[0], 2, 6);
    analyze(5, 6, 11);
    checkOutput("busy done count", 64'(cntDone), 64'd2);
    checkOutput("busy first done", 64'(firstDone), 64'd5);
    checkOutput("busy second done", 64'(lastDone), 64'd11);
    checkOutput("busy write count", 64'(cntWe), 64'd2);
    checkOutput("busy write cyc3", 64'({logWe[3], logWaddr[3], logWdata[3]}), 64'({1'b1, 9'd0, vecs[0].dataA}));
    checkOutput("busy write cyc9", 64'({logWe[9], logWaddr[9], logWdata[9]}), 64'({1'b1, 9'd0, vecs[0].dataA}));
    checkOutput("busy apply bad cycles", 64'(applyBad), 64'd0);

    // Asynchronous reset in the middle of cycle 2 of a backtrack sweep.
    mem1[0] = vecs[0].w0;
    mem1[1] = vecs[0].w1;
    mode1 = 1'b0; nv1 = 12'd3; lvl1 = 16'd5; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset apply before", 64'(apply1), 64'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("midreset apply/done/we", 64'({apply1, done1, we1}), 64'd0);
    checkOutput("midreset raddr/waddr/wdata", 64'({raddr1, waddr1, wdata1}), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    cntWe = 0; applyBad = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (we1 === 1'b1) cntWe++;
      if (apply1 !== 1'b0) applyBad++;
    end
    checkOutput("midreset later writes", 64'(cntWe), 64'd0);
    checkOutput("midreset later apply", 64'(applyBad), 64'd0);

    // RD_LATENCY=3 instance: four words, every lane a decision at the backtrack level.
    for (int a = 0; a < 4; a++) mem3[a] = {3'b010, 16'd2, 3'b010, 16'd2};
    mode3 = 1'b0; nv3 = 12'd8; lvl3 = 16'd2; start3 = 1'b1;
    record3(0);
    for (int c = 1; c < MAXC; c++) begin
      @(posedge clk); #1;
      start3 = 1'b0;
      record3(c);
    end
    analyze(9, 0, 0);
    checkOutput("lat3 write count", 64'(cntWe), 64'd4);
    for (int c = 5; c <= 8; c++)
      checkOutput($sformatf("lat3 write cyc%0d", c), 64'({logWe[c], logWaddr[c], logWdata[c]}),
                  64'({1'b1, 9'(c - 5), 3'b100, 16'd2, 3'b100, 16'd2}));
    checkOutput("lat3 done count", 64'(cntDone), 64'd1);
    checkOutput("lat3 done cycle", 64'(firstDone), 64'd9);
    checkOutput("lat3 apply bad cycles", 64'(applyBad), 64'd0);
    checkOutput("lat3 flip_cnt", 64'(flip3), STATS ? 64'd8 : 64'd0);
    checkOutput("lat3 clr_cnt", 64'(clr3), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bkt_var_sweep.md
# bkt_var_sweep

Parametrised backtrack sweeper for the bin manager's variable-state BRAM. On a start pulse it sweeps every variable of the global problem. In backtrack mode it flips the decision variable at the backtrack level and clears all deeper assignments. In clear mode, used for restart, it clears every assignment at or above the level. It packs `LANES` variables per RAM word, tolerates a configurable BRAM read latency, and holds a BRAM-mux request for the whole sweep.

## Interface
Parameters:
- `WIDTH_VAR`, 12: width of the variable count.
- `WIDTH_LVL`, 16: width of a decision level.
- `LANES`, 2: variables per RAM word. Each lane field is `F = 3+WIDTH_LVL` bits, laid out as `{value[2:0], lvl}`. Lane 0 is in the LSBs.
- `ADDR_WIDTH_VAR_STATES`, 9: RAM word address width.
- `RD_LATENCY`, 1: cycles from `ram_raddr_vs_o` to a valid `ram_rdata_vs_i`. Allowed range is 1..4.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start_bkt_i`, in, 1: start pulse; only accepted in IDLE.
- `mode_i`, in, 1: 0 = backtrack (flip plus clear), 1 = clear-only.
- `nv_all_i`, in, `WIDTH_VAR`: number of variables.
- `bkt_lvl_i`, in, `WIDTH_LVL`: backtrack level; must be at least 1.
- `apply_bkt_o`, out, 1: BRAM mux request.
- `done_bkt_o`, out, 1: one-cycle completion pulse.
- `ram_raddr_vs_o`, out, `ADDR_WIDTH_VAR_STATES`: read address.
- `ram_rdata_vs_i`, in, `LANES*F`: read data.
- `ram_we_vs_o`, out, 1: write enable.
- `ram_waddr_vs_o`, out, `ADDR_WIDTH_VAR_STATES`: write address.
- `ram_wdata_vs_o`, out, `LANES*F`: write data.
- `flip_cnt_o`, out, `WIDTH_VAR`: lanes flipped in the last sweep.
- `clr_cnt_o`, out, `WIDTH_VAR`: lanes cleared in the last sweep.

## Operation
- **States:** IDLE, ISSUE, DRAIN, DONE.
  - IDLE → ISSUE on `start_bkt_i`.
  - ISSUE → DRAIN after the last word address is issued, or immediately when W=0.
  - DRAIN → DONE after `RD_LATENCY+1` cycles.
  - DONE → IDLE.
- **Input capture:** `mode_i`, `nv_all_i` and `bkt_lvl_i` are captured on acceptance. Later changes are ignored until the next start.
- **Word count:** W = ceil(`nv_all_i`/`LANES`). Words 0..W-1 are each read exactly once, in ascending order, one per cycle.
- **Lane validity:** a lane is valid when its index word×`LANES`+lane < `nv_all_i`. A lane is assigned when `value[2:1]` ≠ 0.
- **Per valid, assigned lane, in priority order:**
  - `mode`=0, `lvl`==`bkt_lvl`, `value[0]`==0 (decision): flip. The lane is written as `{~value[2:1], value[0], lvl}`.
  - `lvl` ≥ `bkt_lvl`: clear. The lane is written as all zeros.
  - Otherwise the lane passes through unchanged.
- **Pass-through lanes:** invalid and unassigned lanes are always passed through bit-exact.
- **Write policy:**
  - `ram_we_vs_o` is asserted only if at least one lane of the word is modified.
  - A fully unchanged word produces no write.
  - `ram_waddr_vs_o` is the read address delayed through the pipeline.
- **Hazards:** each address is read once and written at most once, so there is no read/write hazard.
- **Start while busy:** a start outside IDLE is ignored with no side effect.

## Timing
Timing is relative to acceptance at cycle 0, i.e. `start_bkt_i` high while in IDLE. L = `RD_LATENCY`.
- **Read:** `ram_raddr_vs_o` is registered; word k is presented at cycle k+1.
- **Data:** word k's data is sampled at cycle k+1+L.
- **Write:** the write for word k, if any, is registered out at cycle k+2+L. The last possible write is at cycle W+1+L.
- **Done:** `done_bkt_o` is high for exactly cycle W+2+L. For W=0 that is cycle 2+L, with no reads or writes.
- **Mux request:** `apply_bkt_o` is high on cycles 1..W+2+L inclusive and low in IDLE.
- **Reset values:** all outputs reset to 0 and the state goes to IDLE.
- **Reset mid-sweep:** asynchronous; any pending writes are dropped.
- **Counters:** cleared at acceptance, incremented per lane action, and held after DONE until the next start.

## Configuration
- `BKT_SWEEP_STATS_EN` defined: `flip_cnt_o` and `clr_cnt_o` are implemented as described above.
- `BKT_SWEEP_STATS_EN` undefined: the counters are not synthesised and both outputs are tied to 0. All other behaviour is identical.

## Test plan
All scenarios use `LANES`=2, `WIDTH_LVL`=16, L=1 unless stated.

- **Backtrack mode:** `nv_all`=3, `bkt_lvl`=5, `mode`=0.
  - Word 0 holds lane0 `{010,5}` and lane1 `{011,7}`.
  - Word 1 holds lane0 `{100,2}`; lane1 holds junk 0x5A5A5.
  - Required: a single write to addr 0 at cycle 3, with data lane0 `{100,5}` and lane1 0.
  - No write to addr 1. `done_bkt_o` at cycle 5. `flip_cnt`=1, `clr_cnt`=1.
- **Clear mode:** same data with `mode`=1.
  - Required: addr 0 written as all zeros. `flip_cnt`=0, `clr_cnt`=2.
- **Empty problem:** `nv_all`=0.
  - Required: `ram_we_vs_o` never asserted. `apply_bkt_o` high on cycles 1–3. `done_bkt_o` at cycle 3.
- **Start while busy:** `start_bkt_i` re-pulsed at cycle 2 of the backtrack-mode sweep.
  - Required: ignored, with exactly one `done_bkt_o`.
  - A start one cycle after DONE is accepted and produces a second done.
- **Reset mid-sweep:** `rst` low at cycle 2 (async, mid-cycle).
  - Required: all outputs read 0 immediately, the state is IDLE, and no further writes occur.
- **Read latency 3:** `RD_LATENCY`=3, `nv_all`=8 (W=4).
  - Required: writes at cycles 5..8. `done_bkt_o` at cycle 9. `apply_bkt_o` high on cycles 1..9.
